median_window_feeder: RTL and testbench

Streaming producer for the 3-pixel compare-and-swap sorter stage. Accepts a raster-order pixel stream over valid/ready and keeps two previous image rows in line buffers. Emits one complete 3x3 neighbourhood per accepted interior pixel, with centre coordinates, ready for the median filter's CAS network. Sits between the pixel source and the median filter core.

---
 rtl/median_pkg.sv | 15 +
 rtl/median_line_buffer.sv | 25 ++
 rtl/median_window_feeder.sv | 139 +++++++++++++
 tb/tb_median_window_feeder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types and window layout for the median filter datapath.
// The window is nine pixels, element (r,c) at flat index 3*r+c, r=0 oldest row.
package median_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_N = 9;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [WIN_N-1:0][PIX_W-1:0] win_t;

    function automatic int win_idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/median_line_buffer.sv
// One image line of delay: combinational read of the old value at addr,
// overwritten with wr_data on wr_en. Contents are deliberately not reset.
module median_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/median_window_feeder.sv
// Raster pixel stream in, one 3x3 neighbourhood per interior pixel out.
// Optional MEDIAN_FEEDER_SOF_EN adds in_sof, which forces the accepted pixel to (0,0).
module median_window_feeder
    import median_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef MEDIAN_FEEDER_SOF_EN
    input  logic                        in_sof,
`endif
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_pixel,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIN_N*DATA_W-1:0]     out_win,
    output logic [$clog2(IMG_H)-1:0]    out_row,
    output logic [$clog2(IMG_W)-1:0]    out_col,
    output logic                        out_eof
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

    logic [RW-1:0] row_q, row_d, cur_row, out_row_q, out_row_d;
    logic [CW-1:0] col_q, col_d, cur_col, out_col_q, out_col_d;
    logic [WIN_N*DATA_W-1:0] win_q, win_d;
    logic out_valid_q, out_valid_d, out_eof_q, out_eof_d;
    logic accept, emit, sof;
    logic [DATA_W-1:0] top_pix, mid_pix;

`ifdef MEDIAN_FEEDER_SOF_EN
    assign sof = in_sof;
`else
    assign sof = 1'b0;
`endif

    // Handshake: a pixel transfers when in_valid && in_ready; a window transfers
    // when out_valid && out_ready; outputs stay frozen while out_valid && !out_ready.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    median_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (cur_col),
        .wr_data (mid_pix),
        .rd_data (top_pix)
    );

    median_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (cur_col),
        .wr_data (in_pixel),
        .rd_data (mid_pix)
    );

    always_comb begin
        cur_row = sof ? '0 : row_q;
        cur_col = sof ? '0 : col_q;
        emit    = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        row_d   = row_q;
        col_d   = col_q;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    // Columns shift toward c=0 on every accept, borders included, so the
    // window is already primed when the first interior pixel arrives.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_d[win_idx(r, c)*DATA_W +: DATA_W] = win_q[win_idx(r, c + 1)*DATA_W +: DATA_W];
                end
            end
            win_d[win_idx(0, 2)*DATA_W +: DATA_W] = top_pix;
            win_d[win_idx(1, 2)*DATA_W +: DATA_W] = mid_pix;
            win_d[win_idx(2, 2)*DATA_W +: DATA_W] = in_pixel;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_eof_d   = out_eof_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_row_d   = cur_row - RW'(1);
            out_col_d   = cur_col - CW'(1);
            out_eof_d   = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            col_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_eof_q   <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_eof_q   <= out_eof_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_win   = win_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for median_window_feeder on a 4x4 image: table vectors, hand sequences
// and randomized traffic against an image-array reference model.
module tb_median_window_feeder;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int RW = $clog2(IH);
    localparam int CW = $clog2(IW);
    localparam int WW = 9 * DW;
`ifdef MEDIAN_FEEDER_SOF_EN
    localparam bit SOF_EN = 1'b1;
`else
    localparam bit SOF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pixel;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] out_win;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          out_eof;
`ifdef MEDIAN_FEEDER_SOF_EN
    logic          in_sof;
`endif

    always #5 clk = ~clk;

    median_window_feeder #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MEDIAN_FEEDER_SOF_EN
        .in_sof    (in_sof),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_win   (out_win),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_eof   (out_eof)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the frame as a 2D image plus a raster position.
    logic [DW-1:0] img [IH][IW];
    int            m_p = 0;
    logic          m_valid = 1'b0;
    logic [WW-1:0] m_win = '0;
    int            m_row = 0;
    int            m_col = 0;
    logic          m_eof = 1'b0;
    logic [WW-1:0] exp_q[$];
    int            wins_seen = 0;
    int            eofs_seen = 0;

    typedef struct {
        logic [DW-1:0] pix;
        logic          ev;
        int            er;
        int            ec;
        logic          ee;
        logic [WW-1:0] ewin;
    } vec_t;
    vec_t tbl[16];

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] win_at(input int r, input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*DW +: DW] = img[r-2+i][c-2+j];
        return w;
    endfunction

    function automatic logic [DW-1:0] pv(input int p, input int base);
        return DW'(base + 16 * (p / IW) + (p % IW));
    endfunction

    // One clock: drive at negedge, check handshake before the edge, model and check after it.
    task automatic step(input logic v, input logic [DW-1:0] pix, input logic rdy,
                        input logic s, input logic r, output logic acc);
        logic exp_ready;
        int   pr, pc;
        in_valid = v; in_pixel = pix; out_ready = rdy; rst = r;
`ifdef MEDIAN_FEEDER_SOF_EN
        in_sof = s;
`endif
        #1;
        exp_ready = !m_valid || rdy;
        if (!r) check("in_ready", WW'(in_ready), WW'(exp_ready));
        if (!r && out_valid === 1'b1 && rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_window", WW'(1), WW'(0));
            end else begin
                check("sb_window", out_win, exp_q.pop_front());
            end
            wins_seen++;
            if (out_eof === 1'b1) eofs_seen++;
        end
        acc = v && exp_ready && !r;
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 1'b0; m_p = 0;
            exp_q.delete();
        end else if (acc) begin
            if (SOF_EN && s) m_p = 0;
            pr = m_p / IW;
            pc = m_p % IW;
            img[pr][pc] = pix;
            if (pr >= 2 && pc >= 2) begin
                m_valid = 1'b1;
                m_win   = win_at(pr, pc);
                m_row   = pr - 1;
                m_col   = pc - 1;
                m_eof   = (pr == IH - 1) && (pc == IW - 1);
                exp_q.push_back(m_win);
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            m_p = (m_p + 1) % (IW * IH);
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        check("out_valid", WW'(out_valid), WW'(m_valid));
        if (m_valid) begin
            check("out_win", out_win, m_win);
            check("out_row", WW'(out_row), WW'(m_row));
            check("out_col", WW'(out_col), WW'(m_col));
            check("out_eof", WW'(out_eof), WW'(m_eof));
        end
        @(negedge clk);
    endtask

    task automatic drain();
        logic a;
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
        check("queue_empty", WW'(exp_q.size()), WW'(0));
    endtask

    initial begin
        logic a;
        int   p, cyc, w0, e0;
        logic [3:0] pat;

        for (int i = 0; i < 16; i++) begin
            tbl[i].pix = pv(i, 0);
            tbl[i].ev = 1'b0; tbl[i].er = 0; tbl[i].ec = 0; tbl[i].ee = 1'b0; tbl[i].ewin = '0;
        end
        tbl[10] = '{8'h22, 1'b1, 1, 1, 1'b0, 72'h22_21_20_12_11_10_02_01_00};
        tbl[11] = '{8'h23, 1'b1, 1, 2, 1'b0, 72'h23_22_21_13_12_11_03_02_01};
        tbl[14] = '{8'h32, 1'b1, 2, 1, 1'b0, 72'h32_31_30_22_21_20_12_11_10};
        tbl[15] = '{8'h33, 1'b1, 2, 2, 1'b1, 72'h33_32_31_23_22_21_13_12_11};

        in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0; rst = 1'b1;
`ifdef MEDIAN_FEEDER_SOF_EN
        in_sof = 1'b0;
`endif
        @(negedge clk);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
        check("rst_out_valid", WW'(out_valid), WW'(0));
        check("rst_out_win", out_win, '0);
        check("rst_out_row", WW'(out_row), WW'(0));
        check("rst_out_col", WW'(out_col), WW'(0));
        check("rst_out_eof", WW'(out_eof), WW'(0));

        // 1: table-driven frame with continuous flow
        w0 = wins_seen; e0 = eofs_seen;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, tbl[i].pix, 1'b1, 1'b0, 1'b0, a);
            check("t1_accept", WW'(a), WW'(1));
            check("t1_valid", WW'(out_valid), WW'(tbl[i].ev));
            if (tbl[i].ev) begin
                check("t1_win", out_win, tbl[i].ewin);
                check("t1_row", WW'(out_row), WW'(tbl[i].er));
                check("t1_col", WW'(out_col), WW'(tbl[i].ec));
                check("t1_eof", WW'(out_eof), WW'(tbl[i].ee));
            end
        end
        drain();
        check("t1_windows", WW'(wins_seen - w0), WW'(4));
        check("t1_eofs", WW'(eofs_seen - e0), WW'(1));

        // 2: out_ready pattern 1,0,0,1
        pat = 4'b1001; p = 0; cyc = 0; w0 = wins_seen;
        while (p < 16 && cyc < 200) begin
            step(1'b1, pv(p, 0), pat[cyc % 4], 1'b0, 1'b0, a);
            if (a) p++;
            cyc++;
        end
        check("t2_all_accepted", WW'(p), WW'(16));
        drain();
        check("t2_windows", WW'(wins_seen - w0), WW'(4));

        // 3: two back-to-back frames
        w0 = wins_seen; e0 = eofs_seen;
        for (int i = 0; i < 32; i++) step(1'b1, pv(i % 16, (i < 16) ? 0 : 'h80), 1'b1, 1'b0, 1'b0, a);
        drain();
        check("t3_windows", WW'(wins_seen - w0), WW'(8));
        check("t3_eofs", WW'(eofs_seen - e0), WW'(2));

        // 4: reset while a window is pending, then a full frame
        for (int i = 0; i < 11; i++) step(1'b1, pv(i, 0), 1'b1, 1'b0, 1'b0, a);
        check("t4_pending", WW'(out_valid), WW'(1));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
        check("t4_valid_after_rst", WW'(out_valid), WW'(0));
        w0 = wins_seen;
        for (int i = 0; i < 16; i++) step(1'b1, pv(i, 'h40), 1'b1, 1'b0, 1'b0, a);
        drain();
        check("t4_windows", WW'(wins_seen - w0), WW'(4));

        // 5a: in_valid gapped every other cycle, random out_ready
        p = 0; cyc = 0; w0 = wins_seen;
        while (p < 48 && cyc < 2000) begin
            step(cyc % 2 == 0, pv(p % 16, 0), 1'($urandom_range(0, 1)), 1'b0, 1'b0, a);
            if (a) p++;
            cyc++;
        end
        check("t5a_all_accepted", WW'(p), WW'(48));
        drain();
        check("t5a_windows", WW'(wins_seen - w0), WW'(12));

        // 5b: fully random traffic and pixel values
        p = 0; cyc = 0; w0 = wins_seen;
        while (p < 64 && cyc < 4000) begin
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0, 1'b0, 1'b0, a);
            if (a) p++;
            cyc++;
        end
        check("t5b_all_accepted", WW'(p), WW'(64));
        drain();
        check("t5b_windows", WW'(wins_seen - w0), WW'(16));

`ifdef MEDIAN_FEEDER_SOF_EN
        // 6: partial frame, then in_sof restarts counting
        for (int i = 0; i < 5; i++) step(1'b1, DW'('hF0 + i), 1'b1, 1'b0, 1'b0, a);
        w0 = wins_seen; e0 = eofs_seen;
        for (int i = 0; i < 16; i++) step(1'b1, pv(i, 'h40), 1'b1, i == 0, 1'b0, a);
        drain();
        check("t6_windows", WW'(wins_seen - w0), WW'(4));
        check("t6_eofs", WW'(eofs_seen - e0), WW'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
